// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone slave memory with byte-lane writes, programmable wait states and address error checks.
module wb_slave_mem #(
  parameter int          BUS_WIDTH   = 32,
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cyc,
  input  logic                   stb,
  input  logic [31:0]            adr,
  input  logic [BUS_WIDTH/8-1:0] sel,
  input  logic                   we,
  input  logic [BUS_WIDTH-1:0]   datSlvIn,
  output logic [BUS_WIDTH-1:0]   datMstIn,
  output logic                   ack,
  output logic                   err
);
  localparam int          NB   = BUS_WIDTH / 8;
  localparam int          LB   = $clog2(NB);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SIZE = 33'(DEPTH * NB);
  localparam logic [31:0] MASK = 32'(NB - 1);
  localparam logic [3:0]  LAST = 4'(WAIT_STATES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;
  state_t                 state, next;
  logic [3:0]             cnt;
  logic [31:0]            adr_q, cur_adr;
  logic [NB-1:0]          sel_q, cur_sel;
  logic                   we_q, cur_we, take, bad, enter_term;
  logic [BUS_WIDTH-1:0]   dat_q, cur_dat;
  logic [32:0]            off;
  logic [AW-1:0]          idx;
  logic [BUS_WIDTH-1:0]   mem [DEPTH];
  // With zero wait states the request terminates on its capture edge, so decode the live inputs in IDLE.
  always_comb begin
    take       = state == IDLE && cyc && stb;
    cur_adr    = state == IDLE ? adr : adr_q;
    cur_sel    = state == IDLE ? sel : sel_q;
    cur_we     = state == IDLE ? we : we_q;
    cur_dat    = state == IDLE ? datSlvIn : dat_q;
    off        = {1'b0, cur_adr} - {1'b0, BASE_ADDR};
    idx        = AW'(off[31:0] >> LB);
    bad        = off >= SIZE || (cur_adr & MASK) != '0;
    next       = state == IDLE ? (take ? (WAIT_STATES > 0 ? WAIT : TERM) : IDLE)
               : state == WAIT ? (!cyc ? IDLE : cnt == LAST ? TERM : WAIT) : IDLE;
    enter_term = next == TERM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      datMstIn <= '0;
    end else begin
      state    <= next;
      cnt      <= state == WAIT ? cnt + 4'd1 : '0;
      ack      <= enter_term && !bad;
      err      <= enter_term && bad;
      datMstIn <= enter_term && !bad && !cur_we ? mem[idx] : '0;
    end
    if (take) begin
      adr_q <= adr;
      sel_q <= sel;
      we_q  <= we;
      dat_q <= datSlvIn;
    end
  end
  always_ff @(posedge clk)
    if (!rst && enter_term && !bad && cur_we)
      for (int i = 0; i < NB; i++)
        if (cur_sel[i]) mem[idx][8*i +: 8] <= cur_dat[8*i +: 8];
endmodule

// File: doc/wb_slave_mem.md
WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 The module SHALL have parameter BUS_WIDTH, default 32, data bus width in bits; legal values are 8, 16, 32 and 64.
REQ-002 The module SHALL have parameter DEPTH, default 256, memory size in BUS_WIDTH-bit words; it SHALL be a power of 2 and at least 2.
REQ-003 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; it SHALL be aligned to DEPTH*BUS_WIDTH/8.
REQ-004 The module SHALL have parameter WAIT_STATES, default 0, extra cycles inserted before ack/err; legal range is 0..15.
REQ-005 The module SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  clock; all state SHALL change on its rising edge only.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 cyc  input  1  Wishbone bus cycle valid.
REQ-009 stb  input  1  Wishbone strobe.
REQ-010 adr  input  32  byte address.
REQ-011 sel  input  BUS_WIDTH/8  byte-lane selects; bit i selects data bits [8i+7:8i].
REQ-012 we  input  1  write enable; 1 = write, 0 = read.
REQ-013 datSlvIn  input  BUS_WIDTH  write data, master to slave.
REQ-014 datMstIn  output  BUS_WIDTH  read data, slave to master.
REQ-015 ack  output  1  normal termination.
REQ-016 err  output  1  error termination.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT, TERM.
REQ-018 In IDLE, when cyc&stb is sampled high, the module SHALL capture adr, sel, we and datSlvIn, then go to WAIT if WAIT_STATES>0, else to TERM.
REQ-019 WAIT SHALL count WAIT_STATES cycles with a 4-bit counter, then go to TERM.
REQ-020 If cyc is sampled low in WAIT, the module SHALL abort to IDLE with no memory write and no ack/err.
REQ-021 TERM SHALL last exactly one cycle, assert exactly one of ack or err, then go to IDLE unconditionally.
REQ-022 Latency: for a request sampled at edge N, ack/err SHALL be high for the single cycle following edge N+WAIT_STATES.
REQ-023 Minimum transfer period SHALL be WAIT_STATES+2 cycles; a strobe held high after termination SHALL be treated as a new request at the next IDLE sample.
REQ-024 Error conditions, evaluated on the captured request: address outside [BASE_ADDR, BASE_ADDR+DEPTH*BUS_WIDTH/8-1], or low log2(BUS_WIDTH/8) address bits nonzero.
REQ-025 On any error condition, TERM SHALL assert err, not ack, perform no write, and drive datMstIn to 0.
REQ-026 The word index SHALL be (adr-BASE_ADDR)>>log2(BUS_WIDTH/8), truncated to log2(DEPTH) bits.
REQ-027 A write SHALL update only the bytes whose sel bit is 1, at the edge that enters TERM.
REQ-028 A write with sel all zero SHALL be acked and SHALL leave memory unchanged.
REQ-029 A read SHALL drive datMstIn with the full word, independent of sel, during the ack cycle; datMstIn SHALL be 0 in all other cycles.
REQ-030 A read issued after a write terminates SHALL return the written data.
REQ-031 ack and err SHALL be registered outputs and SHALL never be high in the same cycle.

Reset
REQ-032 rst high at a clock edge SHALL force IDLE, wait counter 0, ack=0, err=0, datMstIn=0 on that edge, regardless of state.
REQ-033 A transaction in WAIT or TERM when reset is applied SHALL be discarded: no write, and no ack/err after reset.
REQ-034 Memory contents SHALL NOT be cleared by reset.
REQ-035 Requests present while rst is high SHALL be ignored.

Verification
REQ-036 BUS_WIDTH=32, WAIT_STATES=0: write 0xDEADBEEF to 0x10, sel=4'hF, then read 0x10 -> ack 1 cycle after each request; read returns 0xDEADBEEF.
REQ-037 Partial write: write 0x11223344 with sel=4'b0101 over 0xDEADBEEF at 0x10, then read -> 0xDE22BE44.
REQ-038 WAIT_STATES=3: read request sampled at edge N -> ack high only in the cycle after edge N+3; abort by dropping cyc at N+2 -> no ack, memory unchanged.
REQ-039 DEPTH=256, BASE_ADDR=0: access 0x400 (out of range) and 0x11 (misaligned) -> err=1 for one cycle, ack=0, datMstIn=0, no write.
REQ-040 Assert rst while in WAIT -> next cycle: ack=0, err=0, FSM in IDLE; a subsequent read of the target address returns the pre-transaction value.
REQ-041 BUS_WIDTH=64 and BUS_WIDTH=8 builds: write/read of top and bottom words (index 0 and DEPTH-1) -> correct data; index DEPTH -> err.
